player_move_sequencer: RTL and testbench

- Sequences player motion for the maze game: once per game tick it samples the direction buttons and computes a clamped target position.
- Hands the target to an external legality/trap checker over a req/ack handshake, then commits or discards the move.
- Replaces ad-hoc per-tick position arithmetic; owns pos_x/pos_y, which feed the VGA sprite compare and the game FSM.

---
 rtl/player_move_sequencer_if.sv | 21 ++
 rtl/player_move_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_player_move_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/player_move_sequencer_if.sv
// Checker handshake between the move sequencer (master) and the legality/trap checker (slave).
interface player_move_sequencer_if;
    localparam int unsigned COORD_W = 10;

    logic               chk_req;
    logic [COORD_W-1:0] chk_x;
    logic [COORD_W-1:0] chk_y;
    logic               chk_ack;
    logic               chk_ok;
    logic               chk_trap;

    modport master (
        output chk_req, chk_x, chk_y,
        input  chk_ack, chk_ok, chk_trap
    );

    modport slave (
        input  chk_req, chk_x, chk_y,
        output chk_ack, chk_ok, chk_trap
    );
endinterface

// File: rtl/player_move_sequencer.sv
// Per-tick player motion: samples buttons, proposes a clamped target to the checker,
// then commits, discards or freezes on a trap. Owns the committed sprite position.
module player_move_sequencer #(
    parameter int unsigned TICK_DIV    = 2097152,
    parameter int unsigned STEP        = 4,
    parameter int unsigned X_INIT      = 320,
    parameter int unsigned Y_INIT      = 70,
    parameter int unsigned X_MIN       = 60,
    parameter int unsigned X_MAX       = 560,
    parameter int unsigned Y_MIN       = 60,
    parameter int unsigned Y_MAX       = 460,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic        board_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load_init,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_l,
    input  logic        btn_r,
    player_move_sequencer_if.master chk,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        moved,
    output logic        trap_hit,
    output logic        chk_err,
    output logic        busy
);
    localparam int unsigned CW  = 10;
    localparam int unsigned AW  = CW + 1;
    localparam int unsigned TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned WW  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

    state_e          state_q, state_d;
    logic [TCW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [CW-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [CW-1:0]   chk_x_q, chk_x_d, chk_y_q, chk_y_d;
    logic            chk_req_q, chk_req_d;
    logic            moved_q, moved_d;
    logic            trap_hit_q, trap_hit_d;
    logic            chk_err_q, chk_err_d;
    logic            busy_q, busy_d;
    logic            tick_c;
    logic [CW-1:0]   tgt_x_c, tgt_y_c;

    // One-step move on an axis with an 11-bit intermediate; saturates, never wraps below the minimum.
    function automatic logic [CW-1:0] step_axis(input logic [CW-1:0] cur, input logic inc,
                                                input logic dec, input logic [AW-1:0] lo,
                                                input logic [AW-1:0] hi);
        logic [AW-1:0] wide;
        wide = {1'b0, cur};
        if (inc && !dec) begin
            wide = wide + AW'(STEP);
        end else if (dec && !inc) begin
            wide = (wide < lo + AW'(STEP)) ? lo : wide - AW'(STEP);
        end
        if (wide < lo) begin
            wide = lo;
        end else if (wide > hi) begin
            wide = hi;
        end
        return wide[CW-1:0];
    endfunction

    assign tick_c  = enable && !load_init && (tick_cnt_q == TCW'(TICK_DIV - 1));
    assign tgt_x_c = step_axis(pos_x_q, btn_r, btn_l, AW'(X_MIN), AW'(X_MAX));
    assign tgt_y_c = step_axis(pos_y_q, btn_d, btn_u, AW'(Y_MIN), AW'(Y_MAX));

    // State register and all registered outputs.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            wait_q     <= '0;
            pos_x_q    <= CW'(X_INIT);
            pos_y_q    <= CW'(Y_INIT);
            chk_x_q    <= CW'(X_INIT);
            chk_y_q    <= CW'(Y_INIT);
            chk_req_q  <= 1'b0;
            moved_q    <= 1'b0;
            trap_hit_q <= 1'b0;
            chk_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            wait_q     <= wait_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            chk_x_q    <= chk_x_d;
            chk_y_q    <= chk_y_d;
            chk_req_q  <= chk_req_d;
            moved_q    <= moved_d;
            trap_hit_q <= trap_hit_d;
            chk_err_q  <= chk_err_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; load_init overrides everything, ticks outside IDLE are dropped.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        chk_x_d    = chk_x_q;
        chk_y_d    = chk_y_q;
        chk_req_d  = chk_req_q;
        moved_d    = 1'b0;
        trap_hit_d = 1'b0;
        chk_err_d  = 1'b0;

        if (!enable || load_init || tick_c) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TCW'(1);
        end

        if (load_init) begin
            state_d   = IDLE;
            wait_d    = '0;
            pos_x_d   = CW'(X_INIT);
            pos_y_d   = CW'(Y_INIT);
            chk_x_d   = CW'(X_INIT);
            chk_y_d   = CW'(Y_INIT);
            chk_req_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick_c && ((tgt_x_c != pos_x_q) || (tgt_y_c != pos_y_q))) begin
                        chk_x_d   = tgt_x_c;
                        chk_y_d   = tgt_y_c;
                        chk_req_d = 1'b1;
                        wait_d    = '0;
                        state_d   = REQ;
                    end
                end
                REQ: begin
                    if (!enable) begin
                        chk_req_d = 1'b0;
                        state_d   = IDLE;
                    end else if (chk.chk_ack) begin
                        chk_req_d = 1'b0;
                        if (chk.chk_trap) begin
                            trap_hit_d = 1'b1;
                            state_d    = HOLD;
                        end else if (chk.chk_ok) begin
                            pos_x_d = chk_x_q;
                            pos_y_d = chk_y_q;
                            moved_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (wait_q == WW'(ACK_TIMEOUT - 1)) begin
                        chk_err_d = 1'b1;
                        chk_req_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
                HOLD: begin
                    state_d = HOLD;
                end
                default: begin
                    chk_req_d = 1'b0;
                    state_d   = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign chk.chk_req = chk_req_q;
    assign chk.chk_x   = chk_x_q;
    assign chk.chk_y   = chk_y_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign moved       = moved_q;
    assign trap_hit    = trap_hit_q;
    assign chk_err     = chk_err_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_player_move_sequencer.sv
// Directed bench for player_move_sequencer: the bench plays the checker and keeps a
// queue of expected proposals plus a reference position model.
module tb_player_move_sequencer;
    localparam int TICK_DIV = 8;
    localparam int STEP     = 4;
    localparam int X_INIT   = 320;
    localparam int Y_INIT   = 70;
    localparam int X_MIN    = 60;
    localparam int X_MAX    = 560;
    localparam int Y_MIN    = 60;
    localparam int Y_MAX    = 460;
    localparam int ACK_TO   = 64;

    logic       board_clk = 1'b0;
    logic       reset, enable, load_init;
    logic       btn_u, btn_d, btn_l, btn_r;
    logic [9:0] pos_x, pos_y;
    logic       moved, trap_hit, chk_err, busy;

    player_move_sequencer_if chk_if ();

    player_move_sequencer #(
        .TICK_DIV(TICK_DIV), .STEP(STEP), .X_INIT(X_INIT), .Y_INIT(Y_INIT),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .board_clk(board_clk), .reset(reset), .enable(enable), .load_init(load_init),
        .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
        .chk(chk_if),
        .pos_x(pos_x), .pos_y(pos_y), .moved(moved), .trap_hit(trap_hit),
        .chk_err(chk_err), .busy(busy)
    );

    always #5 board_clk = ~board_clk;

    typedef struct { int x; int y; } req_t;
    req_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ex = X_INIT;
    int   ey = Y_INIT;
    int   last_tx = X_INIT;
    int   last_ty = Y_INIT;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge board_clk);
    endtask

    function automatic int tgt(input int p, input logic inc, input logic dec, input int lo, input int hi);
        int v;
        v = p;
        if (inc && !dec) v = p + STEP;
        else if (dec && !inc) v = p - STEP;
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        return v;
    endfunction

    // Expected proposal from the current buttons and model position.
    task automatic push_move();
        req_t e;
        e.x = tgt(ex, btn_r, btn_l, X_MIN, X_MAX);
        e.y = tgt(ey, btn_d, btn_u, Y_MIN, Y_MAX);
        exp_q.push_back(e);
    endtask

    task automatic expect_req(input int budget);
        bit   seen;
        req_t e;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (chk_if.chk_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step(1);
        end
        check("req_seen", 32'(seen), 32'd1);
        e = exp_q.pop_front();
        last_tx = e.x;
        last_ty = e.y;
        check("chk_x", 32'(chk_if.chk_x), 32'(e.x));
        check("chk_y", 32'(chk_if.chk_y), 32'(e.y));
    endtask

    // Answer the pending request and check the one-cycle outcome.
    task automatic finish_req(input int dly, input logic ok, input logic trap);
        logic commit;
        step(dly);
        chk_if.chk_ack  = 1'b1;
        chk_if.chk_ok   = ok;
        chk_if.chk_trap = trap;
        {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
        step(1);
        chk_if.chk_ack  = 1'b0;
        chk_if.chk_ok   = 1'b0;
        chk_if.chk_trap = 1'b0;
        commit = !trap && ok;
        if (commit) begin
            ex = last_tx;
            ey = last_ty;
        end
        check("moved", 32'(moved), 32'(commit));
        check("trap_hit", 32'(trap_hit), 32'(trap));
        check("req_drop", 32'(chk_if.chk_req), 32'd0);
        check("busy_after_ack", 32'(busy), 32'(trap));
        check("pos_x", 32'(pos_x), 32'(ex));
        check("pos_y", 32'(pos_y), 32'(ey));
        step(1);
        check("pulse_clear", 32'(moved | trap_hit), 32'd0);
    endtask

    task automatic no_req_window(input string tag, input int cycles, input logic exp_busy);
        logic any_req, any_idle;
        any_req  = 1'b0;
        any_idle = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            step(1);
            any_req  |= chk_if.chk_req;
            any_idle |= ~busy;
        end
        check(tag, 32'(any_req), 32'd0);
        if (exp_busy) check({tag, "_busy"}, 32'(any_idle), 32'd0);
    endtask

    initial begin
        int k;
        reset = 1'b1; enable = 1'b0; load_init = 1'b0;
        {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
        chk_if.chk_ack = 1'b0; chk_if.chk_ok = 1'b0; chk_if.chk_trap = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
        check("rst_pos_x", 32'(pos_x), 32'(X_INIT));
        check("rst_pos_y", 32'(pos_y), 32'(Y_INIT));
        check("rst_chk_x", 32'(chk_if.chk_x), 32'(X_INIT));
        check("rst_chk_y", 32'(chk_if.chk_y), 32'(Y_INIT));
        check("rst_flags", 32'({chk_if.chk_req, moved, trap_hit, chk_err, busy}), 32'd0);

        // Stray ack while idle and disabled.
        chk_if.chk_ack = 1'b1; chk_if.chk_ok = 1'b1; btn_r = 1'b1;
        step(1);
        chk_if.chk_ack = 1'b0; chk_if.chk_ok = 1'b0;
        no_req_window("idle_disabled", 2 * TICK_DIV, 1'b0);
        check("idle_ack_pos", 32'(pos_x), 32'(X_INIT));
        btn_r = 1'b0;

        // Basic move right twice.
        enable = 1'b1;
        btn_r = 1'b1; push_move(); expect_req(4 * TICK_DIV); finish_req(2, 1'b1, 1'b0);
        btn_r = 1'b1; push_move(); expect_req(4 * TICK_DIV); finish_req(2, 1'b1, 1'b0);

        // Back to start, then walk up into the top clamp.
        load_init = 1'b1; step(1); load_init = 1'b0;
        ex = X_INIT; ey = Y_INIT;
        check("init_pos_x", 32'(pos_x), 32'(X_INIT));
        check("init_pos_y", 32'(pos_y), 32'(Y_INIT));
        btn_u = 1'b1; push_move(); expect_req(4 * TICK_DIV); finish_req(1, 1'b1, 1'b0);
        btn_u = 1'b1; push_move(); expect_req(4 * TICK_DIV); finish_req(1, 1'b1, 1'b0);
        {btn_u, btn_l} = 2'b11; push_move(); expect_req(4 * TICK_DIV); finish_req(1, 1'b1, 1'b0);
        {btn_u, btn_d, btn_l} = 3'b111; push_move(); expect_req(4 * TICK_DIV); finish_req(1, 1'b1, 1'b0);
        btn_u = 1'b1;
        no_req_window("clamped_no_req", 3 * TICK_DIV, 1'b0);
        btn_u = 1'b0;

        // Reject leaves position untouched.
        btn_r = 1'b1; push_move(); expect_req(4 * TICK_DIV); finish_req(1, 1'b0, 1'b0);

        // Timeout: chk_err exactly ACK_TO cycles after chk_req rises.
        btn_r = 1'b1; push_move(); expect_req(4 * TICK_DIV);
        btn_r = 1'b0;
        k = 0;
        for (int c = 1; c <= ACK_TO + 20; c++) begin
            step(1);
            if (chk_err === 1'b1) begin
                k = c;
                break;
            end
        end
        check("timeout_cycles", 32'(k), 32'(ACK_TO));
        check("timeout_req", 32'(chk_if.chk_req), 32'd0);
        check("timeout_pos", 32'(pos_x), 32'(ex));
        step(1);
        check("err_pulse_clear", 32'(chk_err), 32'd0);

        // Held request while buttons toggle across a tick.
        btn_d = 1'b1; push_move(); expect_req(4 * TICK_DIV);
        for (int c = 0; c < 20; c++) begin
            {btn_u, btn_d, btn_l, btn_r} = 4'($urandom_range(0, 15));
            step(1);
            check("held_x", 32'(chk_if.chk_x), 32'(last_tx));
            check("held_y", 32'(chk_if.chk_y), 32'(last_ty));
            check("held_req", 32'(chk_if.chk_req), 32'd1);
        end
        finish_req(0, 1'b1, 1'b0);
        no_req_window("no_second_req", 2 * TICK_DIV, 1'b0);

        // Trap: ack with trap and ok, freeze until load_init.
        btn_l = 1'b1; push_move(); expect_req(4 * TICK_DIV); finish_req(1, 1'b1, 1'b1);
        btn_l = 1'b1;
        no_req_window("hold_no_req", 5 * TICK_DIV, 1'b1);
        check("hold_pos_x", 32'(pos_x), 32'(ex));
        btn_l = 1'b0;
        load_init = 1'b1; step(1); load_init = 1'b0;
        ex = X_INIT; ey = Y_INIT;
        check("trap_init_x", 32'(pos_x), 32'(X_INIT));
        check("trap_init_y", 32'(pos_y), 32'(Y_INIT));
        check("trap_init_busy", 32'(busy), 32'd0);

        // Asynchronous reset during a handshake.
        btn_r = 1'b1; push_move(); expect_req(4 * TICK_DIV);
        btn_r = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("areset_chk_x", 32'(chk_if.chk_x), 32'(X_INIT));
        check("areset_pos", 32'({pos_x, pos_y}), 32'({10'(X_INIT), 10'(Y_INIT)}));
        check("areset_flags", 32'({chk_if.chk_req, moved, trap_hit, chk_err, busy}), 32'd0);
        step(1);
        reset = 1'b0;

        // Enable drop aborts the request and clears the tick counter.
        btn_r = 1'b1; push_move(); expect_req(4 * TICK_DIV);
        enable = 1'b0;
        step(1);
        check("abort_req", 32'(chk_if.chk_req), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pulses", 32'({moved, trap_hit, chk_err}), 32'd0);
        enable = 1'b1;
        push_move();
        k = 0;
        for (int c = 1; c <= 4 * TICK_DIV; c++) begin
            step(1);
            if (chk_if.chk_req === 1'b1) begin
                k = c;
                break;
            end
        end
        check("restart_tick_latency", 32'(k), 32'(TICK_DIV));
        expect_req(1);
        finish_req(1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
